// File: rtl/load_store_unit.sv
// MEM-stage data memory initiator: turns byte-addressed loads/stores into word transactions,
// splitting accesses that cross a word boundary and aligning/extending load data.
module load_store_unit #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic                  stall,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic [31:0]           mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ST2  = 2'd1;
    localparam logic [1:0] LD1  = 2'd2;
    localparam logic [1:0] LD2  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [DATA_W-1:0]     wd_q, buf_q, rd_q;

    logic                  fire, buf_en;
    logic                  cur_load;
    logic [DM_ADDRESS-1:0] cur_addr, word0, word1;
    logic [2:0]            cur_f3;
    logic [DATA_W-1:0]     cur_wd;
    logic [1:0]            offset;
    logic [3:0]            base_mask;
    logic [7:0]            lane_mask;
    logic                  split;
    logic [DATA_W-1:0]     wdata_lo, wdata_hi;
    logic [DATA_W-1:0]     lo_word, aligned, load_result;
    logic [2*DATA_W-1:0]   pair;

    assign fire = (state_q == IDLE) & req_valid & (MemRead | MemWrite) & ~reset;

    // Outside IDLE the latched request is authoritative; LD1/LD2 both have bit 1 set.
    assign cur_addr = (state_q == IDLE) ? addr     : addr_q;
    assign cur_f3   = (state_q == IDLE) ? Funct3   : funct3_q;
    assign cur_wd   = (state_q == IDLE) ? wd       : wd_q;
    assign cur_load = (state_q == IDLE) ? MemRead  : state_q[1];

    // Byte/half codes differ between loads (LBU/LHU exist) and stores (100/101 mean word).
    always_comb begin
        base_mask = 4'b1111;
        if (cur_f3[1:0] == 2'b00 && (cur_load || !cur_f3[2])) begin
            base_mask = 4'b0001;
        end else if (cur_f3[1:0] == 2'b01 && (cur_load || !cur_f3[2])) begin
            base_mask = 4'b0011;
        end
    end

    assign offset    = cur_addr[1:0];
    assign lane_mask = {4'b0000, base_mask} << offset;
    assign split     = |lane_mask[7:4];
    assign word0     = {cur_addr[DM_ADDRESS-1:2], 2'b00};
    assign word1     = word0 + DM_ADDRESS'(4);

    assign wdata_lo = cur_wd << {offset, 3'b000};
    assign wdata_hi = cur_wd >> (6'd32 - {1'b0, offset, 3'b000});

    assign lo_word = (state_q == LD2) ? buf_q : mem_rdata;
    assign pair    = {mem_rdata, lo_word} >> {offset, 3'b000};
    assign aligned = pair[DATA_W-1:0];

    always_comb begin
        case (cur_f3)
            3'b000:  load_result = {{(DATA_W-8){aligned[7]}}, aligned[7:0]};
            3'b001:  load_result = {{(DATA_W-16){aligned[15]}}, aligned[15:0]};
            3'b100:  load_result = {{(DATA_W-8){1'b0}}, aligned[7:0]};
            3'b101:  load_result = {{(DATA_W-16){1'b0}}, aligned[15:0]};
            default: load_result = aligned;
        endcase
    end

    // Reset suppresses all memory strobes so a pending second write or load completion is dropped.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = 32'd0;
        mem_wdata = '0;
        rd_valid  = 1'b0;
        buf_en    = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        mem_addr = 32'(word0);
                        if (MemRead) begin
                            mem_re  = 1'b1;
                            stall   = 1'b1;
                            state_d = LD1;
                        end else begin
                            mem_we    = lane_mask[3:0];
                            mem_wdata = wdata_lo;
                            if (split) begin
                                stall   = 1'b1;
                                state_d = ST2;
                            end
                        end
                    end
                end
                ST2: begin
                    mem_addr  = 32'(word1);
                    mem_we    = lane_mask[7:4];
                    mem_wdata = wdata_hi;
                    state_d   = IDLE;
                end
                LD1: begin
                    if (split) begin
                        mem_re   = 1'b1;
                        mem_addr = 32'(word1);
                        stall    = 1'b1;
                        buf_en   = 1'b1;
                        state_d  = LD2;
                    end else begin
                        rd_valid = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    rd_valid = 1'b1;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    assign rd = rd_valid ? load_result : rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wd_q     <= '0;
            buf_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                addr_q   <= addr;
                funct3_q <= Funct3;
                wd_q     <= wd;
            end
            if (buf_en) begin
                buf_q <= mem_rdata;
            end
            if (rd_valid) begin
                rd_q <= load_result;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-organised data memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] rd;
    logic        rd_valid;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    logic [31:0] mem [0:127];
    logic        mem_clr;

    load_store_unit #(
        .DM_ADDRESS(9),
        .DATA_W    (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Funct3   (Funct3),
        .addr     (addr),
        .wd       (wd),
        .stall    (stall),
        .rd       (rd),
        .rd_valid (rd_valid),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data returns one cycle after mem_re; writes land per byte lane.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (mem_we[l]) mem[mem_addr[8:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
        if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_bits(input logic [3:0] we);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{we[l]}};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f, input logic [8:0] a,
                         input logic [31:0] d);
        req_valid = 1'b1;
        MemRead   = r;
        MemWrite  = w;
        Funct3    = f;
        addr      = a;
        wd        = d;
    endtask

    task automatic run_store(input string tag, input logic [2:0] f, input logic [8:0] a,
                             input logic [31:0] d, input logic split,
                             input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
                             input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] wd1);
        issue(1'b0, 1'b1, f, a, d);
        #1;
        check_eq({tag, " addr0"}, mem_addr, a0);
        check_eq({tag, " we0"}, {28'd0, mem_we}, {28'd0, we0});
        check_eq({tag, " wdata0"}, mem_wdata & lane_bits(we0), wd0);
        check_eq({tag, " stall0"}, {31'd0, stall}, {31'd0, split});
        check_eq({tag, " re0"}, {31'd0, mem_re}, 32'd0);
        tick();
        idle();
        // Scramble live inputs: the second part must come from the latched copy.
        addr = 9'h155;
        wd   = 32'h5A5A5A5A;
        #1;
        if (split) begin
            check_eq({tag, " addr1"}, mem_addr, a1);
            check_eq({tag, " we1"}, {28'd0, mem_we}, {28'd0, we1});
            check_eq({tag, " wdata1"}, mem_wdata & lane_bits(we1), wd1);
            check_eq({tag, " stall1"}, {31'd0, stall}, 32'd0);
            tick();
            #1;
        end
        check_eq({tag, " idle_we"}, {28'd0, mem_we}, 32'd0);
    endtask

    task automatic run_load(input string tag, input logic [2:0] f, input logic [8:0] a,
                            input logic split, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] exp);
        issue(1'b1, 1'b0, f, a, 32'd0);
        #1;
        check_eq({tag, " re0"}, {31'd0, mem_re}, 32'd1);
        check_eq({tag, " addr0"}, mem_addr, a0);
        check_eq({tag, " stall0"}, {31'd0, stall}, 32'd1);
        tick();
        idle();
        Funct3 = 3'b010;
        addr   = 9'h0AA;
        #1;
        if (split) begin
            check_eq({tag, " re1"}, {31'd0, mem_re}, 32'd1);
            check_eq({tag, " addr1"}, mem_addr, a1);
            check_eq({tag, " stall1"}, {31'd0, stall}, 32'd1);
            check_eq({tag, " early_valid"}, {31'd0, rd_valid}, 32'd0);
            tick();
            #1;
        end
        check_eq({tag, " valid"}, {31'd0, rd_valid}, 32'd1);
        check_eq({tag, " rd"}, rd, exp);
        check_eq({tag, " stall_done"}, {31'd0, stall}, 32'd0);
        tick();
        #1;
        check_eq({tag, " rd_hold"}, rd, exp);
        check_eq({tag, " valid_drop"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        mem_clr = 1'b1;
        Funct3  = 3'b000;
        addr    = 9'd0;
        wd      = 32'd0;
        idle();
        tick();
        mem_clr = 1'b0;
        tick();
        check_eq("rst stall", {31'd0, stall}, 32'd0);
        check_eq("rst rd", rd, 32'd0);
        check_eq("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst mem_re", {31'd0, mem_re}, 32'd0);
        check_eq("rst mem_we", {28'd0, mem_we}, 32'd0);
        check_eq("rst mem_addr", mem_addr, 32'd0);
        check_eq("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        run_store("sw", 3'b010, 9'h010, 32'hAABBCCDD, 1'b0,
                  32'h10, 4'b1111, 32'hAABBCCDD, 32'h0, 4'b0000, 32'h0);
        run_store("sb", 3'b000, 9'h013, 32'h000000EE, 1'b0,
                  32'h10, 4'b1000, 32'hEE000000, 32'h0, 4'b0000, 32'h0);
        run_load("lb", 3'b000, 9'h013, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEE);
        run_load("lbu", 3'b100, 9'h013, 1'b0, 32'h10, 32'h0, 32'h000000EE);
        run_store("sw_split", 3'b010, 9'h006, 32'hAABBCCDD, 1'b1,
                  32'h04, 4'b1100, 32'hCCDD0000, 32'h08, 4'b0011, 32'h0000AABB);
        run_store("sb80", 3'b000, 9'h007, 32'h00000080, 1'b0,
                  32'h04, 4'b1000, 32'h80000000, 32'h0, 4'b0000, 32'h0);
        run_store("sb91", 3'b000, 9'h008, 32'h00000091, 1'b0,
                  32'h08, 4'b0001, 32'h00000091, 32'h0, 4'b0000, 32'h0);
        run_load("lh_split", 3'b001, 9'h007, 1'b1, 32'h04, 32'h08, 32'hFFFF9180);
        run_load("lhu_split", 3'b101, 9'h007, 1'b1, 32'h04, 32'h08, 32'h00009180);
        run_store("sw_top", 3'b010, 9'h1FC, 32'h11223344, 1'b0,
                  32'h1FC, 4'b1111, 32'h11223344, 32'h0, 4'b0000, 32'h0);
        run_store("sw_w0", 3'b010, 9'h000, 32'h55667788, 1'b0,
                  32'h0, 4'b1111, 32'h55667788, 32'h0, 4'b0000, 32'h0);
        run_load("lw_wrap", 3'b010, 9'h1FE, 1'b1, 32'h1FC, 32'h000, 32'h77881122);
        // Store halfword coded 101 is treated as a word-size store.
        run_store("s101_word", 3'b101, 9'h012, 32'h0000CAFE, 1'b1,
                  32'h10, 4'b1100, 32'hCAFE0000, 32'h14, 4'b0011, 32'h00000000);

        // Read and write together: load wins, no write strobe.
        issue(1'b1, 1'b1, 3'b010, 9'h010, 32'hFFFFFFFF);
        #1;
        check_eq("both we0", {28'd0, mem_we}, 32'd0);
        check_eq("both re0", {31'd0, mem_re}, 32'd1);
        tick();
        idle();
        #1;
        check_eq("both valid", {31'd0, rd_valid}, 32'd1);
        check_eq("both rd", rd, 32'hCAFECCDD);
        check_eq("both we1", {28'd0, mem_we}, 32'd0);
        tick();

        // Reset while the second store part is pending.
        issue(1'b0, 1'b1, 3'b010, 9'h006, 32'h12345678);
        #1;
        check_eq("rst_st2 stall0", {31'd0, stall}, 32'd1);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_st2 we", {28'd0, mem_we}, 32'd0);
        check_eq("rst_st2 stall", {31'd0, stall}, 32'd0);
        check_eq("rst_st2 word8", mem[2], 32'h0000AA91);
        tick();

        // Reset while a load waits for its data.
        issue(1'b1, 1'b0, 3'b010, 9'h010, 32'd0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_ld1 valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_ld1 stall", {31'd0, stall}, 32'd0);
        check_eq("rst_ld1 rd", rd, 32'd0);
        tick();
        check_eq("rst_ld1 late_valid", {31'd0, rd_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the RISC-V pipeline's data memory. It turns load/store requests (byte address, Funct3, store data) into word-aligned memory transactions with per-byte write enables. It aligns and sign/zero-extends load data. Accesses that cross a word boundary are split into two word transactions, and the pipeline is stalled while the split completes.

## Interface
- DM_ADDRESS, 9, byte-address width of data memory
- DATA_W, 32, data width (fixed at 32; other values unsupported)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a memory instruction
- MemRead  in  1  load request (from control unit)
- MemWrite  in  1  store request (from control unit)
- Funct3  in  3  instruction bits 14:12
- addr  in  DM_ADDRESS  byte address (ALU result LSBs)
- wd  in  DATA_W  store data (rs2)
- stall  out  1  hold pipeline registers this cycle
- rd  out  DATA_W  load result
- rd_valid  out  1  one-cycle pulse: rd carries a completed load
- mem_addr  out  32  word-aligned byte address (bits 1:0 = 0, zero-extended)
- mem_re  out  1  read strobe
- mem_we  out  4  byte-lane write enables, lane i = bits 8i+7:8i
- mem_wdata  out  DATA_W  lane-positioned write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re

## Operation
- Sizes by Funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is treated as word size.
- Request fires when req_valid & (MemRead | MemWrite) in IDLE. MemRead wins if both are set. The request (addr, Funct3, wd, kind) is latched at fire.
- Offset o = addr[1:0], size n ∈ {1,2,4}. The access is split when o+n > 4.
  - First part: word addr&~3, lanes o..min(3,o+n-1).
  - Second part: word (addr&~3)+4 modulo 2^DM_ADDRESS, lanes 0..o+n-5.
- Store data: first part mem_wdata = wd << 8o; second part mem_wdata = wd >> 8(4-o). Unused lanes are don't-care with we=0.
- Load data: bytes are gathered from lane o upward, continuing into lane 0 of the second word. The result is zero-extended for LBU/LHU and sign-extended from bit 8n-1 for LB/LH.
- FSM states: IDLE, ST2, LD1, LD2.
  - IDLE, store fire: drive first part on mem_we/mem_wdata/mem_addr this cycle. Unsplit: stall=0, stay IDLE. Split: stall=1, go to ST2.
  - ST2: drive second part, stall=0, go to IDLE.
  - IDLE, load fire: mem_re=1 with first word, stall=1, go to LD1.
  - LD1: unsplit → assemble rd from mem_rdata, rd_valid=1, stall=0, go to IDLE. Split → buffer mem_rdata, issue mem_re with second word, stall=1, go to LD2.
  - LD2: assemble rd from buffer + mem_rdata, rd_valid=1, stall=0, go to IDLE.
- In IDLE with no fire: mem_re=0, mem_we=0000, stall=0.
- rd is combinational in the completion cycle and registered afterwards; it holds the last load result.

## Timing
- Reset values: state IDLE; stall 0; rd 0; rd_valid 0; mem_re 0; mem_we 0000; mem_addr 0; mem_wdata 0; buffer 0.
- Aligned store: 1 cycle, 0 stall. Split store: 2 cycles, 1 stall.
- Aligned load: 2 cycles, 1 stall. Split load: 3 cycles, 2 stalls.
- Request inputs are ignored outside IDLE; the latched copy is used.
- Reset asserted in any state: next cycle is IDLE. A pending second write is not issued and a pending load produces no rd_valid.
- Address wrap: a split at the top word (addr with bits [DM_ADDRESS-1:2] all 1) puts its second part at word 0.
- mem_re and mem_we are never both active in a cycle.

## Test plan
- SW 0xAABBCCDD @0x010 → one cycle: mem_addr 0x10, mem_we 1111, mem_wdata 0xAABBCCDD, stall 0.
- SB 0x000000EE @0x013 → mem_we 1000, mem_wdata[31:24]=0xEE. Then LB @0x013 → stall 1 cycle, rd 0xFFFFFFEE, rd_valid 1. LBU gives 0x000000EE.
- Split SW 0xAABBCCDD @0x006 → cycle 0: addr 0x04, we 1100, wdata 0xCCDD0000, stall 1. Cycle 1: addr 0x08, we 0011, wdata 0x0000AABB.
- Split LH @0x007, memory word 0x04 = 0x80xxxxxx, word 0x08 = 0xxxxxxx91 → two stalls, rd 0xFFFF9180. LHU gives 0x00009180.
- Wrap: LW @0x1FE with DM_ADDRESS=9 → reads 0x1FC then 0x000, rd = {word0[15:0], word1FC[31:16]}.
- Reset asserted during ST2 or LD1 → next cycle IDLE, mem_we 0000, no rd_valid. MemRead & MemWrite both high → load performed, no write.
